// File: rtl/sobel_window_gen_pkg.sv
// Shared defaults for the Sobel window path: image geometry, pixel width and
// the window tap layout used when flattening the 3x3 neighbourhood.
package sobel_window_gen_pkg;

  localparam int IMG_W_DEF = 1280;
  localparam int IMG_H_DEF = 854;
  localparam int DW_DEF    = 8;

  // Window rows, top to bottom: previous-previous line, previous line, live pixel.
  typedef enum logic [1:0] {
    WIN_TOP = 2'd0,
    WIN_MID = 2'd1,
    WIN_BOT = 2'd2
  } win_row_e;

endpackage

// File: rtl/sobel_window_gen_line_delay.sv
// One-row delay line: asynchronous read, registered write, so a read and a
// write to the same column in one cycle return the old contents.
module line_delay
  import sobel_window_gen_pkg::*;
#(
  parameter  int DEPTH = IMG_W_DEF,
  parameter  int WIDTH = DW_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: no reset on the storage array; a reset would turn it into flops
  // instead of RAM, and stale contents never reach a valid window anyway.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: raster pixels in, interior neighbourhoods
// out one cycle after the bottom-right pixel of each window is accepted.
module sobel_window_gen
  import sobel_window_gen_pkg::*;
#(
  parameter  int IMG_W = IMG_W_DEF,
  parameter  int IMG_H = IMG_H_DEF,
  parameter  int DW    = DW_DEF,
  localparam int CW    = $clog2(IMG_W),
  localparam int RW    = $clog2(IMG_H)
) (
  input  logic          CK,
  input  logic          RES,
  input  logic [DW-1:0] PIX_IN,
  input  logic          PIX_VALID,
  input  logic          FRAME_START,
  output logic [DW-1:0] S00, S01, S02,
  output logic [DW-1:0] S10, S11, S12,
  output logic [DW-1:0] S20, S21, S22,
  output logic          WIN_VALID,
  output logic [RW-1:0] WIN_ROW,
  output logic [CW-1:0] WIN_COL,
  output logic          FRAME_DONE
);

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  logic [CW-1:0] col, pos_col;
  logic [RW-1:0] row, pos_row;
  logic [DW-1:0] top, mid;
  logic          lb_we, emit;
  logic [DW-1:0] win [3][3];

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pos_col = col;
    pos_row = row;
    if (FRAME_START) begin
      pos_col = '0;
      pos_row = '0;
    end
  end

  assign lb_we = PIX_VALID && !RES;
  assign emit  = PIX_VALID && (pos_row >= RW'(2)) && (pos_col >= CW'(2));

  line_delay #(.DEPTH(IMG_W), .WIDTH(DW)) u_lb_a (
    .clk(CK), .we(lb_we), .addr(pos_col), .wdata(PIX_IN), .rdata(mid)
  );

  line_delay #(.DEPTH(IMG_W), .WIDTH(DW)) u_lb_b (
    .clk(CK), .we(lb_we), .addr(pos_col), .wdata(mid), .rdata(top)
  );

  // NOTE: non-blocking assignments throughout, so every shift stage samples
  // its neighbour's value from before this edge.
  always_ff @(posedge CK) begin
    if (RES) begin
      col        <= '0;
      row        <= '0;
      WIN_VALID  <= 1'b0;
      WIN_ROW    <= '0;
      WIN_COL    <= '0;
      FRAME_DONE <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else if (PIX_VALID) begin
      if (pos_col == LAST_COL) begin
        col <= '0;
        row <= (pos_row == LAST_ROW) ? '0 : pos_row + RW'(1);
      end else begin
        col <= pos_col + CW'(1);
        row <= pos_row;
      end

      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[WIN_TOP][2] <= top;
      win[WIN_MID][2] <= mid;
      win[WIN_BOT][2] <= PIX_IN;

      WIN_VALID  <= emit;
      FRAME_DONE <= emit && (pos_row == LAST_ROW) && (pos_col == LAST_COL);
      if (emit) begin
        WIN_ROW <= pos_row - RW'(1);
        WIN_COL <= pos_col - CW'(1);
      end
    end else begin
      WIN_VALID  <= 1'b0;
      FRAME_DONE <= 1'b0;
    end
  end

  assign S00 = win[0][0];
  assign S01 = win[0][1];
  assign S02 = win[0][2];
  assign S10 = win[1][0];
  assign S11 = win[1][1];
  assign S12 = win[1][2];
  assign S20 = win[2][0];
  assign S21 = win[2][1];
  assign S22 = win[2][2];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen: a frame-array reference model queues
// expected windows as pixels are driven; a monitor pops and compares them.
module tb_sobel_window_gen;

  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int DW    = 8;
  localparam int RW    = $clog2(IMG_H);
  localparam int CW    = $clog2(IMG_W);

  logic          CK = 1'b0;
  logic          RES = 1'b1;
  logic [DW-1:0] PIX_IN = '0;
  logic          PIX_VALID = 1'b0;
  logic          FRAME_START = 1'b0;
  logic [DW-1:0] S00, S01, S02, S10, S11, S12, S20, S21, S22;
  logic          WIN_VALID;
  logic [RW-1:0] WIN_ROW;
  logic [CW-1:0] WIN_COL;
  logic          FRAME_DONE;

  sobel_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW)) dut (
    .CK(CK), .RES(RES), .PIX_IN(PIX_IN), .PIX_VALID(PIX_VALID),
    .FRAME_START(FRAME_START),
    .S00(S00), .S01(S01), .S02(S02),
    .S10(S10), .S11(S11), .S12(S12),
    .S20(S20), .S21(S21), .S22(S22),
    .WIN_VALID(WIN_VALID), .WIN_ROW(WIN_ROW), .WIN_COL(WIN_COL),
    .FRAME_DONE(FRAME_DONE)
  );

  always #5 CK = ~CK;

  typedef struct packed {
    logic [8:0][7:0] s;
    logic [7:0]      row;
    logic [7:0]      col;
    logic            done;
    logic [31:0]     edge_no;
  } win_t;

  win_t       exp_q[$];
  int         n_vec = 0;
  int         n_fail = 0;
  int         edge_cnt = 0;
  int         win_cnt = 0;
  logic [7:0] img [IMG_H][IMG_W];
  int         mr = 0;
  int         mc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Reference model: store the pixel at its raster position; any pixel at
  // row>=2, col>=2 completes the window centred one up and one left of it.
  task automatic model_accept(input bit fs, input logic [7:0] pix);
    win_t e;
    if (fs) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = pix;
    if (mr >= 2 && mc >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.s[i*3+j] = img[mr-2+i][mc-2+j];
      e.row     = 8'(mr - 1);
      e.col     = 8'(mc - 1);
      e.done    = (mr == IMG_H - 1) && (mc == IMG_W - 1);
      e.edge_no = 32'(edge_cnt + 1);
      exp_q.push_back(e);
    end
    mc++;
    if (mc == IMG_W) begin
      mc = 0;
      mr = (mr == IMG_H - 1) ? 0 : mr + 1;
    end
  endtask

  task automatic drive(input bit res, input bit v, input bit fs, input logic [7:0] pix);
    @(negedge CK);
    #1;
    RES         = res;
    PIX_VALID   = v;
    FRAME_START = fs;
    PIX_IN      = pix;
    if (res) begin
      mr = 0;
      mc = 0;
    end else if (v) begin
      model_accept(fs, pix);
    end
  endtask

  task automatic do_reset(input int n);
    repeat (n) drive(1'b1, 1'($urandom), 1'($urandom), 8'($urandom));
    @(posedge CK);
    #2;
    check("rst_S00", S00, 0); check("rst_S01", S01, 0); check("rst_S02", S02, 0);
    check("rst_S10", S10, 0); check("rst_S11", S11, 0); check("rst_S12", S12, 0);
    check("rst_S20", S20, 0); check("rst_S21", S21, 0); check("rst_S22", S22, 0);
    check("rst_WIN_VALID", WIN_VALID, 0);
    check("rst_WIN_ROW", WIN_ROW, 0);
    check("rst_WIN_COL", WIN_COL, 0);
    check("rst_FRAME_DONE", FRAME_DONE, 0);
  endtask

  // Raster pixels row*16+col; gap inserts an idle cycle after every pixel.
  task automatic send_pixels(input int count, input bit gap, input bit fs_first);
    for (int k = 0; k < count; k++) begin
      int r = (k / IMG_W) % IMG_H;
      int c = k % IMG_W;
      drive(1'b0, 1'b1, fs_first && (k == 0), 8'(r * 16 + c));
      if (gap) drive(1'b0, 1'b0, 1'b0, 8'($urandom));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  // Monitor: runs on the falling edge, away from the DUT's active edge.
  initial begin
    win_t e;
    logic [8:0][7:0] act;
    forever begin
      @(negedge CK);
      act = {S22, S21, S20, S12, S11, S10, S02, S01, S00};
      if (WIN_VALID) begin
        if (exp_q.size() == 0) begin
          check("spurious_WIN_VALID", WIN_VALID, 0);
        end else begin
          e = exp_q.pop_front();
          win_cnt++;
          check("window_latency_edge", edge_cnt, e.edge_no);
          for (int k = 0; k < 9; k++)
            check($sformatf("S%0d%0d", k / 3, k % 3), act[k], e.s[k]);
          check("WIN_ROW", WIN_ROW, e.row);
          check("WIN_COL", WIN_COL, e.col);
          check("FRAME_DONE", FRAME_DONE, e.done);
        end
      end else begin
        check("FRAME_DONE_without_window", FRAME_DONE, 0);
        if (exp_q.size() > 0 && int'(exp_q[0].edge_no) <= edge_cnt) begin
          check("window_missing", WIN_VALID, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge CK);
      edge_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Reset with random inputs.
    do_reset(2);

    // Continuous frame from reset-state counters.
    base = win_cnt;
    send_pixels(IMG_W * IMG_H, 1'b0, 1'b0);
    idle(3);
    check("continuous_window_count", win_cnt - base, 6);

    // Same frame with alternating idle cycles.
    base = win_cnt;
    send_pixels(IMG_W * IMG_H, 1'b1, 1'b1);
    idle(3);
    check("gapped_window_count", win_cnt - base, 6);

    // Two frames back-to-back; second relies on counter wrap only.
    base = win_cnt;
    send_pixels(2 * IMG_W * IMG_H, 1'b0, 1'b1);
    idle(3);
    check("back_to_back_window_count", win_cnt - base, 12);

    // Mid-frame FRAME_START after 7 pixels.
    base = win_cnt;
    send_pixels(7, 1'b0, 1'b1);
    send_pixels(IMG_W * IMG_H, 1'b0, 1'b1);
    idle(3);
    check("mid_frame_restart_window_count", win_cnt - base, 6);

    // Mid-frame reset after 13 pixels, then a fresh frame.
    send_pixels(13, 1'b0, 1'b1);
    do_reset(1);
    base = win_cnt;
    send_pixels(IMG_W * IMG_H, 1'b0, 1'b0);
    idle(3);
    check("post_reset_window_count", win_cnt - base, 6);

    // Random pixel values, random gaps, FRAME_START pulses on idle cycles.
    base = win_cnt;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < IMG_W * IMG_H; k++) begin
        while ($urandom_range(0, 2) == 0)
          drive(1'b0, 1'b0, 1'($urandom), 8'($urandom));
        drive(1'b0, 1'b1, (f == 0) && (k == 0), 8'($urandom));
      end
    end
    idle(3);
    check("random_window_count", win_cnt - base, 18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
